// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, requester ids, latency counter width.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between core and DMA requesters.
// Core has priority until DMA has been passed over STARVE_LIMIT times.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic coreReq,
  input  logic dmaReq,
  input  logic grant,
  output logic winner
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starveCnt;

  // DMA wins when alone, or when it has waited long enough.
  always_comb begin
    winner = REQ_CORE;
    if (dmaReq && (!coreReq || starveCnt == LIMIT))
      winner = REQ_DMA;
  end

  // Count core grants that pass over a waiting DMA request.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (grant) begin
      if (!dmaReq || winner == REQ_DMA)
        starveCnt <= '0;
      else if (starveCnt != LIMIT)
        starveCnt <= starveCnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single data-memory port shared by the MEM stage and a DMA requester.
// One access in flight: issue, optional read wait, one-cycle response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);

  state_t           state;
  logic             latId;
  logic             latWe;
  logic [CNT_W-1:0] cnt;
  logic             winner;
  logic             grant;

  assign grant      = (state == IDLE) && (core_req || dma_req);
  assign core_stall = core_req & ~core_ack;
  assign busy       = (state != IDLE);

  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uPick (
    .clk    (clk),
    .rst    (rst),
    .coreReq(core_req),
    .dmaReq (dma_req),
    .grant  (grant),
    .winner (winner)
  );

  // Transaction sequencer; mem_addr/mem_wdata double as the request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      latId      <= REQ_CORE;
      latWe      <= 1'b0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      dma_rdata  <= '0;
      core_ack   <= 1'b0;
      dma_ack    <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      core_ack <= 1'b0;
      dma_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            latId <= winner;
            state <= ISSUE;
            if (winner == REQ_DMA) begin
              latWe     <= dma_we;
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
            end else begin
              latWe     <= core_we;
              mem_we    <= core_we;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
            end
          end
        end
        ISSUE: begin
          if (latWe || READ_LATENCY == 0) begin
            if (!latWe) begin
              if (latId == REQ_DMA) dma_rdata <= mem_rdata;
              else                  core_rdata <= mem_rdata;
            end
            state    <= RESP;
            core_ack <= (latId == REQ_CORE);
            dma_ack  <= (latId == REQ_DMA);
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (latId == REQ_DMA) dma_rdata <= mem_rdata;
            else                  core_rdata <= mem_rdata;
            state    <= RESP;
            core_ack <= (latId == REQ_CORE);
            dma_ack  <= (latId == REQ_DMA);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Directed table, reset/latency corners, flood and random traffic.
module tb_dmem_arbiter;

  localparam int LAT = 1;
  localparam int SL  = 4;

  logic        clk;
  logic        rst;
  logic        memClr;

  logic        coreReq, coreWe, dmaReq, dmaWe;
  logic [31:0] coreAddr, coreWdata, dmaAddr, dmaWdata;
  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_ack, core_stall, dma_ack, mem_we, busy;

  logic        c0Req, c0We;
  logic [31:0] c0Addr, c0Wdata, c0Rdata, d0Rdata;
  logic        c0Ack, c0Stall, d0Ack, m0We, b0Busy;
  logic [31:0] m0Addr, m0Wdata, m0Rdata;

  logic [31:0] mem  [64];
  logic [31:0] mem0 [64];
  logic [31:0] pipe;

  dmem_arbiter #(.READ_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .core_req(coreReq), .core_we(coreWe),
    .core_addr(coreAddr), .core_wdata(coreWdata),
    .core_rdata(core_rdata), .core_ack(core_ack),
    .core_stall(core_stall),
    .dma_req(dmaReq), .dma_we(dmaWe),
    .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  dmem_arbiter #(.READ_LATENCY(0), .STARVE_LIMIT(SL)) dut0 (
    .clk(clk), .rst(rst),
    .core_req(c0Req), .core_we(c0We),
    .core_addr(c0Addr), .core_wdata(c0Wdata),
    .core_rdata(c0Rdata), .core_ack(c0Ack),
    .core_stall(c0Stall),
    .dma_req(1'b0), .dma_we(1'b0),
    .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(d0Rdata), .dma_ack(d0Ack),
    .mem_we(m0We), .mem_addr(m0Addr),
    .mem_wdata(m0Wdata), .mem_rdata(m0Rdata),
    .busy(b0Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency memory for the main instance.
  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    pipe <= mem[mem_addr[7:2]];
  end
  assign mem_rdata = pipe;

  // Combinational-read memory for the zero-latency instance.
  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 64; i++) mem0[i] <= '0;
    end else if (m0We) begin
      mem0[m0Addr[7:2]] <= m0Wdata;
    end
  end
  assign m0Rdata = mem0[m0Addr[7:2]];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Transaction-level reference model state.
  int          cyc, freeAt, ackCyc, issueCyc, starve;
  bit          pend, pId, pWe, coreAct, dmaAct;
  logic [31:0] pData, expCoreRd, expDmaRd;
  logic [31:0] model [64];
  bit          grants[$];
  logic [31:0] tbCoreRd, tbDmaRd;

  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; memClr = 1'b1;
    coreReq = 1'b0; dmaReq = 1'b0; c0Req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; memClr = 1'b0;
    pend = 0; starve = 0; freeAt = 0; cyc = 0;
    coreAct = 0; dmaAct = 0;
    expCoreRd = '0; expDmaRd = '0;
    tbCoreRd = '0; tbDmaRd = '0;
    for (int i = 0; i < 64; i++) model[i] = '0;
    grants.delete();
  endtask

  task automatic runVec(input vec_t v);
    int k;
    int weCnt;
    bit got;
    if (v.dma) begin
      dmaReq = 1'b1; dmaWe = v.we;
      dmaAddr = v.addr; dmaWdata = v.wdata;
    end else begin
      coreReq = 1'b1; coreWe = v.we;
      coreAddr = v.addr; coreWdata = v.wdata;
    end
    k = 0; weCnt = 0; got = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (mem_we) begin
        weCnt++;
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_wdata", mem_wdata, v.wdata);
      end
      chk("core_stall", core_stall, !v.dma && k != v.lat);
      chk("other ack", v.dma ? core_ack : dma_ack, 0);
      got = v.dma ? dma_ack : core_ack;
      if (v.dma) begin
        dmaWe = 1'($urandom); dmaAddr = $urandom; dmaWdata = $urandom;
      end else begin
        coreWe = 1'($urandom); coreAddr = $urandom; coreWdata = $urandom;
      end
    end
    chk("ack latency", got ? k : 99, v.lat);
    chk("mem_we pulses", weCnt, v.we);
    if (!v.we) begin
      if (v.dma) tbDmaRd = v.expRd;
      else       tbCoreRd = v.expRd;
    end
    chk("core_rdata", core_rdata, tbCoreRd);
    chk("dma_rdata", dma_rdata, tbDmaRd);
    coreReq = 1'b0; dmaReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic run0(input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] expRd);
    int k;
    bit got;
    c0Req = 1'b1; c0We = we; c0Addr = addr; c0Wdata = wdata;
    k = 0; got = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("lat0 mem_we", m0We, we);
      got = c0Ack;
      c0Addr = $urandom; c0Wdata = $urandom;
    end
    chk("lat0 ack latency", got ? k : 99, 2);
    if (!we) chk("lat0 rdata", c0Rdata, expRd);
    c0Req = 1'b0;
    @(negedge clk);
  endtask

  // One cycle of model-checked traffic: 0 random, 1 both always requesting.
  task automatic step(input int mode);
    bit eC, eD, raise, win;
    logic [31:0] a, d;
    @(negedge clk);
    eC = pend && ackCyc == cyc && pId == 1'b0;
    eD = pend && ackCyc == cyc && pId == 1'b1;
    if (eC && !pWe) expCoreRd = pData;
    if (eD && !pWe) expDmaRd = pData;
    chk("core_ack", core_ack, eC);
    chk("dma_ack", dma_ack, eD);
    chk("mem_we", mem_we, pend && issueCyc == cyc && pWe);
    chk("core_stall", core_stall, coreReq & ~eC);
    chk("core_rdata", core_rdata, expCoreRd);
    chk("dma_rdata", dma_rdata, expDmaRd);
    if (eC || eD) begin
      grants.push_back(pId);
      pend = 0;
    end
    if (eC) coreAct = 0;
    if (eD) dmaAct = 0;
    if (!coreAct) begin
      raise = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      coreAct = raise; coreReq = raise;
      coreWe = 1'($urandom_range(0, 1));
      coreAddr = 32'($urandom_range(0, 15)) << 2;
      coreWdata = $urandom;
    end else if (pend && pId == 1'b0) begin
      coreWe = 1'($urandom); coreAddr = $urandom; coreWdata = $urandom;
    end
    if (!dmaAct) begin
      raise = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
      dmaAct = raise; dmaReq = raise;
      dmaWe = 1'($urandom_range(0, 1));
      dmaAddr = 32'($urandom_range(0, 15)) << 2;
      dmaWdata = $urandom;
    end else if (pend && pId == 1'b1) begin
      dmaWe = 1'($urandom); dmaAddr = $urandom; dmaWdata = $urandom;
    end
    if (!pend && cyc >= freeAt && (coreReq || dmaReq)) begin
      win = dmaReq && (!coreReq || starve == SL);
      if (!dmaReq || win) starve = 0;
      else if (starve < SL) starve++;
      pend = 1; pId = win;
      pWe = win ? dmaWe : coreWe;
      a = win ? dmaAddr : coreAddr;
      d = win ? dmaWdata : coreWdata;
      issueCyc = cyc + 1;
      ackCyc = cyc + 2 + (pWe ? 0 : LAT);
      freeAt = ackCyc + 1;
      if (pWe) model[a[7:2]] = d;
      else     pData = model[a[7:2]];
    end
    cyc++;
  endtask

  initial begin
    logic [9:0] order;
    rst = 1'b1; memClr = 1'b1;
    coreReq = 0; coreWe = 0; coreAddr = 0; coreWdata = 0;
    dmaReq = 0; dmaWe = 0; dmaAddr = 0; dmaWdata = 0;
    c0Req = 0; c0We = 0; c0Addr = 0; c0Wdata = 0;

    vecs[0]  = '{1, 1, 32'h0,  32'd1,        32'd0,        2};
    vecs[1]  = '{1, 1, 32'h4,  32'd2,        32'd0,        2};
    vecs[2]  = '{1, 1, 32'h8,  32'd3,        32'd0,        2};
    vecs[3]  = '{1, 1, 32'hC,  32'd4,        32'd0,        2};
    vecs[4]  = '{0, 1, 32'h10, 32'hDEADBEEF, 32'd0,        2};
    vecs[5]  = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 2 + LAT};
    vecs[6]  = '{0, 0, 32'h0,  32'h0,        32'd1,        2 + LAT};
    vecs[7]  = '{0, 0, 32'h4,  32'h0,        32'd2,        2 + LAT};
    vecs[8]  = '{0, 0, 32'h8,  32'h0,        32'd3,        2 + LAT};
    vecs[9]  = '{0, 0, 32'hC,  32'h0,        32'd4,        2 + LAT};
    vecs[10] = '{1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 2 + LAT};

    doReset();
    chk("reset acks", {core_ack, dma_ack, mem_we, busy}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset core_rdata", core_rdata, 0);
    chk("reset dma_rdata", dma_rdata, 0);

    for (int i = 0; i < 11; i++) begin
      runVec(vecs[i]);
      if (i == 3) chk("starve after dma", dut.uPick.starveCnt, 0);
    end

    dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 32'h4;
    @(negedge clk);
    chk("busy in issue", busy, 1);
    @(negedge clk);
    rst = 1'b1; dmaReq = 1'b0;
    @(negedge clk);
    chk("midrst flags", {core_ack, dma_ack, mem_we, busy}, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst mem_wdata", mem_wdata, 0);
    chk("midrst core_rdata", core_rdata, 0);
    chk("midrst dma_rdata", dma_rdata, 0);
    rst = 1'b0;
    tbCoreRd = '0; tbDmaRd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst no dma_ack", {dma_ack, busy}, 0);
    end
    runVec('{0, 0, 32'h8, 32'h0, 32'd3, 2 + LAT});

    run0(1'b1, 32'h20, 32'hA5A50001, 32'h0);
    run0(1'b0, 32'h20, 32'h0, 32'hA5A50001);
    run0(1'b0, 32'h24, 32'h0, 32'h0);

    doReset();
    for (int i = 0; i < 300 && grants.size() < 10; i++) step(1);
    chk("flood grants", grants.size(), 10);
    order = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      if (i < grants.size())
        chk($sformatf("flood grant%0d", i), grants[i], order[i]);
    end

    doReset();
    for (int i = 0; i < 800; i++) step(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single data-memory port between the pipeline MEM stage (core) and a loader/debug DMA requester. Sequences each access through issue, optional read-latency wait and response phases, and generates a core stall while the core's access is outstanding. Sits between the MEM stage and the data memory.

Parameters:
READ_LATENCY, 1, cycles from the issue cycle to valid mem_rdata (0 = combinational read), range 0..7
STARVE_LIMIT, 4, consecutive core grants with dma_req pending before DMA is forced to win, range 1..15

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
core_req  input  1  core access request, held until core_ack
core_we  input  1  core write enable (1 = store)
core_addr  input  32  core byte address
core_wdata  input  32  core store data
core_rdata  output  32  core load data, valid with core_ack
core_ack  output  1  one-cycle completion pulse to core
core_stall  output  1  core_req & ~core_ack; freezes the pipeline
dma_req  input  1  DMA access request, held until dma_ack
dma_we  input  1  DMA write enable
dma_addr  input  32  DMA byte address
dma_wdata  input  32  DMA write data
dma_rdata  output  32  DMA read data, valid with dma_ack
dma_ack  output  1  one-cycle completion pulse to DMA
mem_we  output  1  data-memory write enable
mem_addr  output  32  data-memory address
mem_wdata  output  32  data-memory write data
mem_rdata  input  32  data-memory read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; core_ack, dma_ack, mem_we, busy = 0; mem_addr, mem_wdata, core_rdata, dma_rdata, latched request, latency counter, starve_cnt = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick winner, latch {id, we, addr, wdata} -> ISSUE; else stay.
- Pick: only one req -> that one. Both -> core, unless starve_cnt == STARVE_LIMIT, then DMA.
- starve_cnt: +1 on core grant while dma_req=1 (saturates at STARVE_LIMIT); cleared on DMA grant, or on any grant made while dma_req=0.
- ISSUE: mem_addr/mem_wdata driven from latch (held through WAIT); mem_we=1 for exactly this cycle if write. Write -> RESP. Read with READ_LATENCY=0 -> capture mem_rdata this cycle -> RESP. Read with READ_LATENCY>0 -> load counter with READ_LATENCY -> WAIT.
- WAIT: decrement counter each cycle; in the cycle the counter reaches 1, capture mem_rdata -> RESP.
- RESP: assert winner's ack for exactly one cycle, with the winner's rdata set to the captured value (write: rdata unchanged) -> IDLE. The losing port's rdata is never modified.
- Latency from req sampled in IDLE to ack: write 2 cycles; read 2 + READ_LATENCY cycles. Ack asserts in cycle N+2+READ_LATENCY for IDLE sample cycle N. A request still asserted in the cycle after ack is arbitrated as a new request.
- Latched values are used for the whole transaction; requester input changes after grant have no effect.
- Never more than one transaction in flight; mem_we never asserted outside ISSUE.
- Reset mid-transaction: return to IDLE next cycle with all reset values; in-flight access dropped; no ack issued.
- Address/data are passed through unchanged (no alignment or width conversion).

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP); requester id constants REQ_CORE=0, REQ_DMA=1; latency counter width constant (3 bits).
- One sub-module, dmem_arb_pick: combinational winner selection plus the starve_cnt register, with the update rules above.

Test Plan:
- Core write only (addr 0x10, wdata 0xDEADBEEF) -> mem_we=1 one cycle with mem_addr=0x10, core_ack 2 cycles after req sample, core_stall high until the ack cycle.
- Core read of 0x10 with READ_LATENCY=1 -> core_ack at sample+3 with core_rdata=0xDEADBEEF; dma_rdata unchanged.
- core_req and dma_req both held continuously, STARVE_LIMIT=4 -> grant order C,C,C,C,D,C,C,C,C,D.
- DMA-only writes to 0x0..0xC (data 1..4) followed by core reads -> core reads return 1..4, starve_cnt stays 0.
- rst asserted in WAIT of a DMA read -> no dma_ack, state IDLE next cycle, all outputs 0, later core read completes normally.
- READ_LATENCY=0 read -> ack at sample+2 with data captured during the ISSUE cycle.
